// File: rtl/mcycle_unit.sv
// Iterative multiply/divide unit for the execute stage: one shift-add or
// restoring shift-subtract step per cycle on magnitudes, signs fixed up on the last step.
module mcycle_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, COMPUTING, DONE} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   orig1_q, orig1_d;
  logic [WIDTH-1:0]   result1_q, result1_d;
  logic [WIDTH-1:0]   result2_q, result2_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;

  logic               busy_c;
  logic               neg1, neg2;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     mul_sum, div_rem;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] acc_step, prod;
  logic [WIDTH-1:0]   quo, rem;

  // Operand magnitudes; unsigned ops (MCycleOp[0]=1) never negate
  always_comb begin
    neg1 = ~MCycleOp[0] & Operand1[WIDTH-1];
    neg2 = ~MCycleOp[0] & Operand2[WIDTH-1];
    mag1 = neg1 ? -Operand1 : Operand1;
    mag2 = neg2 ? -Operand2 : Operand2;
  end

  // One iteration. Divide keeps remainder in the upper half and shifts
  // quotient bits into the lower half as the dividend shifts out.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    div_rem  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge   = div_rem >= {1'b0, opnd_q};
    div_diff = div_rem[WIDTH-1:0] - opnd_q;
    if (is_div_q)
      acc_step = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                        : {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    else
      acc_step = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                          : {1'b0, acc_q[2*WIDTH-1:1]};
    prod = neg_res_q ? -acc_step : acc_step;
    quo  = neg_res_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
    rem  = neg_rem_q ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    opnd_d    = opnd_q;
    orig1_d   = orig1_q;
    acc_d     = acc_q;
    result1_d = result1_q;
    result2_d = result2_q;
    busy_c    = 1'b0;
    case (state_q)
      IDLE: if (Start) begin
        busy_c    = 1'b1;
        state_d   = COMPUTING;
        count_d   = '0;
        is_div_d  = MCycleOp[1];
        neg_res_d = neg1 ^ neg2;
        neg_rem_d = neg1;
        div0_d    = (Operand2 == '0);
        orig1_d   = Operand1;
        acc_d     = {{WIDTH{1'b0}}, (MCycleOp[1] ? mag1 : mag2)};
        opnd_d    = MCycleOp[1] ? mag2 : mag1;
      end
      COMPUTING: begin
        busy_c  = 1'b1;
        acc_d   = acc_step;
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH-1)) begin
          state_d = DONE;
          if (!is_div_q) begin
            result1_d = prod[WIDTH-1:0];
            result2_d = prod[2*WIDTH-1:WIDTH];
          end else if (div0_q) begin
            result1_d = '1;
            result2_d = orig1_q;
          end else begin
            result1_d = quo;
            result2_d = rem;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= IDLE;
      count_q   <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      opnd_q    <= '0;
      orig1_q   <= '0;
      acc_q     <= '0;
      result1_q <= '0;
      result2_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      opnd_q    <= opnd_d;
      orig1_q   <= orig1_d;
      acc_q     <= acc_d;
      result1_q <= result1_d;
      result2_q <= result2_d;
    end
  end

  // Start is combinational into Busy, so mask it while reset is held
  assign Busy    = RESET & busy_c;
  assign Result1 = result1_q;
  assign Result2 = result2_q;

endmodule

// File: tb/tb_mcycle_unit.sv
// Randomized bench for mcycle_unit against an arithmetic reference model.
module tb_mcycle_unit;
  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RESET, Start, Busy;
  logic [1:0]   MCycleOp;
  logic [W-1:0] Operand1, Operand2, Result1, Result2;
  logic [W-1:0] prev1, prev2;
  int           n_cmp = 0;
  int           n_err = 0;

  always #5 CLK = ~CLK;

  mcycle_unit #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET(RESET), .Start(Start), .MCycleOp(MCycleOp),
    .Operand1(Operand1), .Operand2(Operand2),
    .Result1(Result1), .Result2(Result2), .Busy(Busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns {Result2, Result1}
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0: p = 64'(sa * sb);
      2'd1: p = {32'd0, a} * {32'd0, b};
      default: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else begin
          if (op == 2'd2) begin q = sa / sb; r = sa % sb; end
          else begin q = longint'({32'd0, a} / {32'd0, b}); r = longint'({32'd0, a} % {32'd0, b}); end
          p = {r[31:0], q[31:0]};
        end
      end
    endcase
    return p;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      4: return 32'($urandom % 16);
      5: return -32'($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit hold);
    logic [63:0] exp;
    int busy_n;
    bit stable;
    exp = model(op, a, b);
    @(negedge CLK);
    Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b;
    #1;
    chk("busy_cycle0", 64'(Busy), 64'd1);
    busy_n = 1;
    stable = (Result1 === prev1) && (Result2 === prev2);
    @(posedge CLK); #1;
    Start = hold; MCycleOp = 2'($urandom); Operand1 = $urandom; Operand2 = $urandom;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (!Busy) break;
      busy_n++;
      if (Result1 !== prev1 || Result2 !== prev2) stable = 0;
      Operand1 = $urandom; Operand2 = $urandom;
    end
    chk("busy_len", 64'(busy_n), 64'(W + 1));
    chk("hold_while_busy", 64'(stable), 64'd1);
    chk("result1", 64'(Result1), 64'(exp[31:0]));
    chk("result2", 64'(Result2), 64'(exp[63:32]));
    prev1 = exp[31:0];
    prev2 = exp[63:32];
  endtask

  initial begin
    RESET = 1'b0; Start = 1'b0; MCycleOp = 2'd0; Operand1 = '0; Operand2 = '0;
    prev1 = '0; prev2 = '0;
    repeat (2) @(negedge CLK);
    Start = 1'b1; #1;
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_r1", 64'(Result1), 64'd0);
    chk("rst_r2", 64'(Result2), 64'd0);
    Start = 1'b0;
    @(negedge CLK); RESET = 1'b1;

    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    @(negedge CLK);
    chk("idle_after_done", 64'(Busy), 64'd0);
    chk("umul_max_hi", 64'(Result2), 64'hFFFF_FFFE);
    chk("umul_max_lo", 64'(Result1), 64'h0000_0001);
    run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 0);
    run_op(2'd1, 32'hFFFF_FFFD, 32'd7, 0);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(2'd3, 32'd100, 32'd0, 0);
    run_op(2'd2, 32'hFFFF_FF9C, 32'd0, 0);

    // Back-to-back with Start held through DONE
    run_op(2'd0, 32'h0001_2345, 32'hFFFF_0F0F, 1);
    run_op(2'd3, 32'hDEAD_BEEF, 32'd13, 1);
    run_op(2'd2, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 0);

    // Reset in the middle of a divide
    @(negedge CLK);
    Start = 1'b1; MCycleOp = 2'd3; Operand1 = 32'd1000; Operand2 = 32'd7;
    @(posedge CLK); #1; Start = 1'b0;
    repeat (9) @(negedge CLK);
    RESET = 1'b0; #1;
    chk("midop_rst_busy", 64'(Busy), 64'd0);
    chk("midop_rst_r1", 64'(Result1), 64'd0);
    chk("midop_rst_r2", 64'(Result2), 64'd0);
    @(negedge CLK); RESET = 1'b1;
    prev1 = '0; prev2 = '0;
    @(negedge CLK);
    chk("post_rst_idle", 64'(Busy), 64'd0);
    run_op(2'd3, 32'd1000, 32'd7, 0);

    for (int k = 0; k < 40; k++)
      run_op(2'($urandom), pick(), pick(), 1'($urandom));
    @(negedge CLK); Start = 1'b0;
    repeat (2) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
